// File: rtl/audio_note_sequencer_pkg.sv
// Shared constants, entry layout and FSM encoding for the note sequencer.
// Start addresses and field offsets for the audio_seq_rom note table.
package audio_note_sequencer_pkg;

   localparam int PERWIDTH       = 16;
   localparam logic PWM_MUTED    = 1'b1;
   localparam int SEQ_DUR_WIDTH  = 8;
   localparam int SEQ_ADDR_WIDTH = 5;

   localparam int ENT_PER_LSB = 0;
   localparam int ENT_DUR_LSB = PERWIDTH;
   localparam int ENT_LOOP    = PERWIDTH + SEQ_DUR_WIDTH;
   localparam int ENT_LAST    = ENT_LOOP + 1;
   localparam int ENT_WIDTH   = ENT_LAST + 1;

   localparam logic [SEQ_ADDR_WIDTH-1:0] SFX0_START = 5'd0;
   localparam logic [SEQ_ADDR_WIDTH-1:0] SFX1_START = 5'd3;
   localparam logic [SEQ_ADDR_WIDTH-1:0] SFX2_START = 5'd5;
   localparam logic [SEQ_ADDR_WIDTH-1:0] SFX3_START = 5'd6;

   typedef enum logic [1:0] {
      SEQ_IDLE  = 2'd0,
      SEQ_FETCH = 2'd1,
      SEQ_PLAY  = 2'd2
   } seq_state_e;

   typedef struct packed {
      logic                     last;
      logic                     loop;
      logic [SEQ_DUR_WIDTH-1:0] dur;
      logic [PERWIDTH-1:0]      period;
   } seq_entry_t;

   function automatic logic [ENT_WIDTH-1:0] mk_entry(
      input logic last, input logic loop, input int dur, input int per);
      seq_entry_t e;
      e.last   = last;
      e.loop   = loop;
      e.dur    = SEQ_DUR_WIDTH'(dur);
      e.period = PERWIDTH'(per);
      return e;
   endfunction

endpackage

// File: rtl/audio_seq_rom.sv
// Note table with 1-cycle synchronous read, plus per-sfx start table.
// Unused addresses hold a terminating rest so a stray read always ends.
module audio_seq_rom
   import audio_note_sequencer_pkg::*;
(
   input  logic                      clk,
   input  logic [SEQ_ADDR_WIDTH-1:0] addr,
   input  logic [1:0]                sfx_sel,
   output logic [ENT_WIDTH-1:0]      q,
   output logic [SEQ_ADDR_WIDTH-1:0] start_addr
);

   always_comb begin
      start_addr = SFX0_START;
      unique case (sfx_sel)
         2'd0: start_addr = SFX0_START;
         2'd1: start_addr = SFX1_START;
         2'd2: start_addr = SFX2_START;
         2'd3: start_addr = SFX3_START;
         default: start_addr = SFX0_START;
      endcase
   end

   always_ff @(posedge clk) begin
      case (addr)
         5'd0:    q <= mk_entry(1'b0, 1'b0, 2, 1000);
         5'd1:    q <= mk_entry(1'b0, 1'b0, 1, 0);
         5'd2:    q <= mk_entry(1'b1, 1'b0, 3, 500);
         5'd3:    q <= mk_entry(1'b0, 1'b0, 4, 800);
         5'd4:    q <= mk_entry(1'b1, 1'b0, 4, 900);
         5'd5:    q <= mk_entry(1'b1, 1'b0, 0, 700);
         5'd6:    q <= mk_entry(1'b0, 1'b0, 2, 300);
         5'd7:    q <= mk_entry(1'b1, 1'b1, 2, 350);
         default: q <= mk_entry(1'b1, 1'b0, 1, 0);
      endcase
   end

endmodule

// File: rtl/audio_note_sequencer.sv
// Trigger-driven note sequencer feeding the sawtooth pulsewidth generator.
// Optional AUDIO_SEQ_LOOP_EN adds looping tables and the stop port.
module audio_note_sequencer
   import audio_note_sequencer_pkg::*;
#(
   parameter int TICK_CYCLES = 100000,
   parameter int NUM_SFX     = 4,
   parameter int ROM_DEPTH   = 32,
   parameter int DUR_WIDTH   = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                trigger,
   input  logic [1:0]          sfx_id,
`ifdef AUDIO_SEQ_LOOP_EN
   input  logic                stop,
`endif
   output logic [PERWIDTH-1:0] period,
   output logic                mute,
   output logic                busy,
   output logic                done
);

   localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
   localparam logic [TW-1:0] TICK_MAX = TW'(TICK_CYCLES - 1);

   seq_state_e                state, state_n;
   logic [SEQ_ADDR_WIDTH-1:0] addr, addr_n, start_addr;
   logic [1:0]                cur_id, cur_id_n, sel;
   logic [TW-1:0]             tick, tick_n;
   logic [DUR_WIDTH-1:0]      dcnt, dcnt_n, dur_last;
   seq_entry_t                cur, cur_n, rom_ent;
   logic [ENT_WIDTH-1:0]      rom_q;
   logic [PERWIDTH-1:0]       period_n;
   logic                      mute_n, busy_n, done_n;
   logic                      take, stop_req, loop_ok;

`ifdef AUDIO_SEQ_LOOP_EN
   assign stop_req = stop;
   assign loop_ok  = 1'b1;
`else
   assign stop_req = 1'b0;
   assign loop_ok  = 1'b0;
`endif

   assign rom_ent  = seq_entry_t'(rom_q);
   assign take     = trigger && (int'(sfx_id) < NUM_SFX)
                     && (state == SEQ_IDLE || sfx_id >= cur_id);
   assign sel      = take ? sfx_id : cur_id;
   assign dur_last = (cur.dur == '0) ? '0 : DUR_WIDTH'(cur.dur - 1'b1);

   audio_seq_rom u_rom (
      .clk        (clk),
      .addr       (addr_n),
      .sfx_sel    (sel),
      .q          (rom_q),
      .start_addr (start_addr)
   );

   always_comb begin
      state_n  = state;
      addr_n   = addr;
      cur_id_n = cur_id;
      tick_n   = tick;
      dcnt_n   = dcnt;
      cur_n    = cur;
      period_n = period;
      mute_n   = mute;
      busy_n   = busy;
      done_n   = 1'b0;
      if (stop_req) begin
         state_n  = SEQ_IDLE;
         tick_n   = '0;
         dcnt_n   = '0;
         period_n = '0;
         mute_n   = PWM_MUTED;
         busy_n   = 1'b0;
      end else if (take) begin
         // Preempt or fresh start: restart from the table head via FETCH.
         state_n  = SEQ_FETCH;
         addr_n   = start_addr;
         cur_id_n = sfx_id;
         tick_n   = '0;
         dcnt_n   = '0;
         busy_n   = 1'b1;
      end else begin
         unique case (state)
            SEQ_FETCH: begin
               state_n  = SEQ_PLAY;
               cur_n    = rom_ent;
               period_n = rom_ent.period;
               mute_n   = (rom_ent.period == '0) ? PWM_MUTED : ~PWM_MUTED;
               tick_n   = '0;
               dcnt_n   = '0;
            end
            SEQ_PLAY: begin
               if (tick != TICK_MAX) begin
                  tick_n = tick + 1'b1;
               end else if (dcnt != dur_last) begin
                  tick_n = '0;
                  dcnt_n = dcnt + 1'b1;
               end else begin
                  tick_n = '0;
                  dcnt_n = '0;
                  if (!cur.last) begin
                     state_n = SEQ_FETCH;
                     addr_n  = (int'(addr) == ROM_DEPTH - 1) ? '0 : addr + 1'b1;
                  end else if (loop_ok && cur.loop) begin
                     state_n = SEQ_FETCH;
                     addr_n  = start_addr;
                  end else begin
                     state_n  = SEQ_IDLE;
                     period_n = '0;
                     mute_n   = PWM_MUTED;
                     busy_n   = 1'b0;
                     done_n   = 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= SEQ_IDLE;
         addr   <= '0;
         cur_id <= '0;
         tick   <= '0;
         dcnt   <= '0;
         cur    <= '0;
         period <= '0;
         mute   <= PWM_MUTED;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         state  <= state_n;
         addr   <= addr_n;
         cur_id <= cur_id_n;
         tick   <= tick_n;
         dcnt   <= dcnt_n;
         cur    <= cur_n;
         period <= period_n;
         mute   <= mute_n;
         busy   <= busy_n;
         done   <= done_n;
      end
   end

endmodule

// File: tb/tb_audio_note_sequencer.sv
// Directed cycle-by-cycle bench for audio_note_sequencer, TICK_CYCLES=4.
// Inputs change and outputs are sampled on the falling edge.
module tb_audio_note_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        trigger;
   logic [1:0]  sfx_id;
`ifdef AUDIO_SEQ_LOOP_EN
   logic        stop;
`endif
   logic [15:0] period;
   logic        mute, busy, done;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   audio_note_sequencer #(.TICK_CYCLES(4)) dut (
      .clk     (clk),
      .reset   (reset),
      .trigger (trigger),
      .sfx_id  (sfx_id),
`ifdef AUDIO_SEQ_LOOP_EN
      .stop    (stop),
`endif
      .period  (period),
      .mute    (mute),
      .busy    (busy),
      .done    (done)
   );

   task automatic chk(input string tag, input logic [15:0] p,
                      input logic m, input logic b, input logic d);
      checks++;
      assert ({period, mute, busy, done} === {p, m, b, d})
      else begin
         failures++;
         $error("FAIL %s t=%0t got p=%0d m=%0b b=%0b d=%0b want p=%0d m=%0b b=%0b d=%0b",
                tag, $time, period, mute, busy, done, p, m, b, d);
      end
   endtask

   task automatic run(input string tag, input int n, input logic [15:0] p,
                      input logic m, input logic b, input logic d);
      for (int i = 0; i < n; i++) begin
         chk(tag, p, m, b, d);
         @(negedge clk);
      end
   endtask

   task automatic pulse(input logic [1:0] id);
      trigger = 1'b1;
      sfx_id  = id;
      @(negedge clk);
      trigger = 1'b0;
   endtask

   initial begin
      reset   = 1'b1;
      trigger = 1'b0;
      sfx_id  = 2'd0;
`ifdef AUDIO_SEQ_LOOP_EN
      stop    = 1'b0;
`endif
      repeat (3) @(negedge clk);
      reset = 1'b0;
      run("idle", 50, 16'd0, 1'b1, 1'b0, 1'b0);

      pulse(2'd0);
      run("s0_fetch0", 1, 16'd0, 1'b1, 1'b1, 1'b0);
      run("s0_p1000", 8, 16'd1000, 1'b0, 1'b1, 1'b0);
      run("s0_fetch1", 1, 16'd1000, 1'b0, 1'b1, 1'b0);
      run("s0_rest", 4, 16'd0, 1'b1, 1'b1, 1'b0);
      run("s0_fetch2", 1, 16'd0, 1'b1, 1'b1, 1'b0);
      run("s0_p500", 12, 16'd500, 1'b0, 1'b1, 1'b0);
      run("s0_done", 1, 16'd0, 1'b1, 1'b0, 1'b1);
      run("s0_after", 3, 16'd0, 1'b1, 1'b0, 1'b0);

      pulse(2'd2);
      run("s2_fetch", 1, 16'd0, 1'b1, 1'b1, 1'b0);
      run("s2_dur0", 4, 16'd700, 1'b0, 1'b1, 1'b0);
      run("s2_done", 1, 16'd0, 1'b1, 1'b0, 1'b1);
      run("s2_after", 2, 16'd0, 1'b1, 1'b0, 1'b0);

      pulse(2'd1);
      run("s1_fetch", 1, 16'd0, 1'b1, 1'b1, 1'b0);
      run("s1_p800", 5, 16'd800, 1'b0, 1'b1, 1'b0);
      pulse(2'd0);
      run("s1_ignore", 4, 16'd800, 1'b0, 1'b1, 1'b0);
      pulse(2'd3);
      run("s3_fetch", 1, 16'd800, 1'b0, 1'b1, 1'b0);
      run("s3_p300", 8, 16'd300, 1'b0, 1'b1, 1'b0);
      run("s3_fetch1", 1, 16'd300, 1'b0, 1'b1, 1'b0);
      run("s3_p350", 8, 16'd350, 1'b0, 1'b1, 1'b0);
`ifdef AUDIO_SEQ_LOOP_EN
      run("s3_loopf", 1, 16'd350, 1'b0, 1'b1, 1'b0);
      run("s3_loop300", 2, 16'd300, 1'b0, 1'b1, 1'b0);
      stop    = 1'b1;
      trigger = 1'b1;
      sfx_id  = 2'd3;
      @(negedge clk);
      stop    = 1'b0;
      trigger = 1'b0;
      run("s3_stop", 4, 16'd0, 1'b1, 1'b0, 1'b0);
`else
      run("s3_done", 1, 16'd0, 1'b1, 1'b0, 1'b1);
      run("s3_after", 2, 16'd0, 1'b1, 1'b0, 1'b0);
`endif

      pulse(2'd0);
      run("rst_fetch", 1, 16'd0, 1'b1, 1'b1, 1'b0);
      run("rst_p1000", 3, 16'd1000, 1'b0, 1'b1, 1'b0);
      reset = 1'b1;
      run("rst_edge", 1, 16'd1000, 1'b0, 1'b1, 1'b0);
      reset = 1'b0;
      run("rst_after", 5, 16'd0, 1'b1, 1'b0, 1'b0);

      pulse(2'd2);
      run("s2b_fetch", 1, 16'd0, 1'b1, 1'b1, 1'b0);
      run("s2b_p700", 4, 16'd700, 1'b0, 1'b1, 1'b0);
      run("s2b_done", 1, 16'd0, 1'b1, 1'b0, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
